multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
- Upstream issue/writeback controller for the multi-cycle mult/div unit in the execute stage.
- Captures a decoded MULT/DIV instruction and its operands, then issues exactly one single-cycle ctrl_MULT/ctrl_DIV pulse with stable operands.
- Stalls the pipeline until the unit reports ready, then emits a one-cycle register-file write of the result or of the exception status code.
- Adds a watchdog so a missing ready can never hang the CPU.

Parameters:
- MULT_EXC_CODE, 4: value written to EXC_REG on mult overflow.
- DIV_EXC_CODE, 5: value written to EXC_REG on divide-by-zero or division timeout.
- EXC_REG, 30: destination register used for exception status ($rstatus).
- TIMEOUT, 64: maximum WAIT cycles before forced abort. Must be ≥ 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  execute-stage instruction valid.
- in_is_mult  in  1  instruction is MULT.
- in_is_div  in  1  instruction is DIV. If in_is_mult is also high, MULT wins.
- in_opA  in  32  operand A.
- in_opB  in  32  operand B.
- in_rd  in  5  destination register.
- flush  in  1  squash any in-flight operation.
- md_opA  out  32  registered operand A to the unit.
- md_opB  out  32  registered operand B to the unit.
- md_ctrl_MULT  out  1  one-cycle start pulse for multiply.
- md_ctrl_DIV  out  1  one-cycle start pulse for divide.
- md_result  in  32  unit result.
- md_exception  in  1  unit exception.
- md_resultRDY  in  1  unit ready.
- stall  out  1  freeze upstream pipeline stages.
- wb_valid  out  1  register-file write enable, one cycle.
- wb_rd  out  5  write address.
- wb_data  out  32  write data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE. All outputs 0, counter 0, operand/rd/op registers 0.
- States: IDLE, START, WAIT, WB. Encoding is free.
- launch = in_valid & (in_is_mult | in_is_div).
- IDLE:
  - stall = launch (combinational).
  - On launch, capture opA, opB, rd, and op (mult if in_is_mult) into registers; go to START.
- START:
  - Exactly one of md_ctrl_MULT/md_ctrl_DIV = 1, per captured op. md_opA/md_opB already hold captured values.
  - stall=1. Counter cleared. md_resultRDY ignored (stale-ready guard).
  - Next state: WAIT.
- WAIT:
  - stall=1. Counter increments each cycle.
  - If md_resultRDY=1: latch md_result and md_exception; go to WB.
  - Else if counter == TIMEOUT-1: force exception=1 and go to WB.
- WB (one cycle):
  - stall=0, so the held instruction advances at this edge. All in_* inputs are ignored in this cycle.
  - If exception: wb_valid=1, wb_rd=EXC_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE per op (timeout always uses DIV_EXC_CODE on div and MULT_EXC_CODE on mult).
  - Else: wb_rd=rd, wb_data=result, wb_valid = (rd != 0). A write to r0 is suppressed.
  - Next state: IDLE.
- Latency: launch cycle → START → WAIT (N cycles until ready) → WB. Minimum WB is 3 cycles after launch when ready arrives on the first WAIT cycle.
- flush:
  - In START or WAIT: go to IDLE next edge, no wb_valid, stall=0 in that cycle. The START pulse is still emitted if flush coincides with START.
  - In IDLE: launch is suppressed.
  - In WB: ignored; the write completes.
- md_opA/md_opB change only on launch capture and are stable from START through WB.
- The ctrl pulse is never asserted outside START and never for two consecutive cycles.
- Reset mid-operation: immediate return to IDLE; outputs drop asynchronously.

Test Plan:
- MULT 7×6, rd=3; ready 2 cycles into WAIT → exactly one md_ctrl_MULT pulse. stall high launch..WAIT. WB: wb_valid=1, wb_rd=3, wb_data=42, stall=0.
- DIV 100/0, rd=5; unit returns exception → wb_rd=30, wb_data=5. No write to r5.
- MULT 0x7FFFFFFF×2 with overflow → wb_rd=30, wb_data=4.
- DIV, rd=4; ready held low → after 64 WAIT cycles WB with wb_rd=30, wb_data=5; busy returns 0 next cycle.
- md_resultRDY held high during START (stale) → ignored; FSM waits for ready in WAIT. Second case: rd=0, result=9 → wb_valid=0.
- Back-to-back MULT then DIV → two distinct pulses with a WB between them. flush in WAIT → IDLE, no write. Async reset mid-WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issue/writeback controller for the multi-cycle mult/div unit.
// Captures a MULT/DIV with its operands, fires a single start pulse, stalls until
// the unit is ready (or a watchdog expires), then performs one register-file write.
module multdiv_issue_ctrl #(
    parameter int unsigned MULT_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE  = 5,
    parameter int unsigned EXC_REG       = 30,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_is_mult,
    input  logic        in_is_div,
    input  logic [31:0] in_opA,
    input  logic [31:0] in_opB,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    logic [1:0]    state;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic [4:0]    rd_q;
    logic          is_mult_q;
    logic [31:0]   result_q;
    logic          exc_q;
    logic [CW-1:0] cnt;
    logic          launch;

    // A flush in IDLE squashes the launch outright.
    assign launch = in_valid & (in_is_mult | in_is_div) & ~flush;

    assign md_opA = op_a;
    assign md_opB = op_b;
    assign busy   = (state != S_IDLE);

    // FSM, operand capture, result latch and watchdog counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            rd_q      <= '0;
            is_mult_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        op_a      <= in_opA;
                        op_b      <= in_opB;
                        rd_q      <= in_rd;
                        is_mult_q <= in_is_mult;
                        result_q  <= '0;
                        exc_q     <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    // Ready is deliberately not sampled here: it may be stale from a prior op.
                    cnt   <= '0;
                    state <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (md_resultRDY) begin
                        result_q <= md_result;
                        exc_q    <= md_exception;
                        state    <= S_WB;
                    end else if (cnt == CNT_LAST) begin
                        exc_q <= 1'b1;
                        state <= S_WB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // State-decoded start pulses, stall and register-file write port.
    always_comb begin
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        case (state)
            S_IDLE: begin
                stall = launch;
            end
            S_START: begin
                md_ctrl_MULT = is_mult_q;
                md_ctrl_DIV  = ~is_mult_q;
                stall        = ~flush;
            end
            S_WAIT: begin
                stall = ~flush;
            end
            S_WB: begin
                if (exc_q) begin
                    wb_valid = 1'b1;
                    wb_rd    = 5'(EXC_REG);
                    wb_data  = is_mult_q ? 32'(MULT_EXC_CODE) : 32'(DIV_EXC_CODE);
                end else begin
                    wb_valid = (rd_q != '0);
                    wb_rd    = rd_q;
                    wb_data  = result_q;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Scoreboard bench for multdiv_issue_ctrl: expected writebacks are queued at launch
// and popped by a monitor whenever the DUT asserts wb_valid.
module tb_multdiv_issue_ctrl;

    localparam int unsigned TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_is_mult = 1'b0;
    logic        in_is_div = 1'b0;
    logic [31:0] in_opA = '0;
    logic [31:0] in_opB = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int mult_pulses = 0;
    int div_pulses = 0;
    int wb_count = 0;
    logic prev_pulse = 1'b0;

    multdiv_issue_ctrl #(
        .MULT_EXC_CODE(4),
        .DIV_EXC_CODE(5),
        .EXC_REG(30),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_is_mult(in_is_mult), .in_is_div(in_is_div),
        .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .flush(flush),
        .md_opA(md_opA), .md_opB(md_opB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: score writebacks, count start pulses, guard pulse shape.
    always @(negedge clock) begin
        if (!reset) begin
            if (wb_valid) begin
                wb_count++;
                if (sb.size() == 0) begin
                    check("wb_unexpected", 32'(wb_valid), 32'd0);
                end else begin
                    wb_exp_t e;
                    e = sb.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_data", wb_data, e.data);
                end
            end
            if (md_ctrl_MULT) mult_pulses++;
            if (md_ctrl_DIV) div_pulses++;
            if (md_ctrl_MULT && md_ctrl_DIV) check("pulse_both", 32'd1, 32'd0);
            if ((md_ctrl_MULT || md_ctrl_DIV) && prev_pulse) check("pulse_consec", 32'd1, 32'd0);
            prev_pulse = md_ctrl_MULT | md_ctrl_DIV;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // delay < 0 means the unit never raises ready (watchdog path).
    task automatic run_op(input logic mult, input logic div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int delay,
                          input logic [31:0] res, input logic exc, input logic stale);
        wb_exp_t e;
        logic exp_exc, exp_write;
        int mp0, dp0, wc0, waited;
        bit done;
        exp_exc   = exc || (delay < 0);
        exp_write = exp_exc || (rd != 5'd0);
        @(negedge clock);
        in_valid = 1'b1; in_is_mult = mult; in_is_div = div;
        in_opA = a; in_opB = b; in_rd = rd;
        #1 check("launch_stall", 32'(stall), 32'd1);
        if (exp_write) begin
            e.rd   = exp_exc ? 5'd30 : rd;
            e.data = exp_exc ? (mult ? 32'd4 : 32'd5) : res;
            sb.push_back(e);
        end
        mp0 = mult_pulses; dp0 = div_pulses; wc0 = wb_count;
        @(negedge clock);
        in_valid = 1'b0; in_is_mult = 1'b0; in_is_div = 1'b0;
        in_opA = $urandom; in_opB = $urandom; in_rd = 5'($urandom);
        md_resultRDY = stale; md_exception = stale; md_result = 32'hDEADBEEF;
        #1;
        check("start_stall", 32'(stall), 32'd1);
        check("start_opA", md_opA, a);
        check("start_opB", md_opB, b);
        check("start_mult", 32'(md_ctrl_MULT), 32'(mult));
        check("start_div", 32'(md_ctrl_DIV), 32'(!mult));
        @(negedge clock);
        md_resultRDY = 1'b0; md_exception = 1'b0;
        waited = 0; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (delay >= 0 && waited == delay) begin
                md_resultRDY = 1'b1; md_result = res; md_exception = exc;
            end
            @(negedge clock);
            waited++;
            md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'hDEADBEEF;
            #1 if (!stall) done = 1;
        end
        check("wb_reached", 32'(done), 32'd1);
        check("wait_cycles", 32'(waited), (delay >= 0) ? 32'(delay + 1) : 32'(TIMEOUT));
        check("wb_busy", 32'(busy), 32'd1);
        check("wb_opA_stable", md_opA, a);
        check("mult_pulse_cnt", 32'(mult_pulses - mp0), 32'(mult));
        check("div_pulse_cnt", 32'(div_pulses - dp0), 32'(!mult));
        check("wb_write_cnt", 32'(wb_count - wc0), 32'(exp_write));
    endtask

    initial begin
        int wc0;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_opA", md_opA, 32'd0);
        check("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        // mult 7x6, ready on second WAIT cycle
        run_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 1, 32'd42, 1'b0, 1'b0);
        // div by zero, unit exception
        run_op(1'b0, 1'b1, 32'd100, 32'd0, 5'd5, 0, 32'd0, 1'b1, 1'b0);
        // mult overflow
        run_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'd2, 5'd8, 2, 32'hFFFFFFFE, 1'b1, 1'b0);
        // div timeout
        run_op(1'b0, 1'b1, 32'd9, 32'd3, 5'd4, -1, 32'd0, 1'b0, 1'b0);
        @(negedge clock); #1 check("timeout_busy_clr", 32'(busy), 32'd0);
        // stale ready during START
        run_op(1'b1, 1'b0, 32'd3, 32'd5, 5'd7, 1, 32'h00001234, 1'b0, 1'b1);
        // rd = 0 suppressed write
        run_op(1'b0, 1'b1, 32'd18, 32'd2, 5'd0, 0, 32'd9, 1'b0, 1'b0);
        // back-to-back mult (both flags: mult wins) then div
        run_op(1'b1, 1'b1, 32'hFFFF, 32'h10, 5'd31, 3, 32'h000FFFF0, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 32'd50, 32'd7, 5'd12, 0, 32'd7, 1'b0, 1'b0);

        // flush in WAIT
        wc0 = wb_count;
        @(negedge clock);
        in_valid = 1'b1; in_is_div = 1'b1; in_rd = 5'd9;
        @(negedge clock); in_valid = 1'b0; in_is_div = 1'b0;
        @(negedge clock); flush = 1'b1;
        #1 check("flush_wait_stall", 32'(stall), 32'd0);
        @(negedge clock); flush = 1'b0;
        #1 check("flush_wait_busy", 32'(busy), 32'd0);
        @(negedge clock); @(negedge clock);
        #1 check("flush_wait_nowb", 32'(wb_count - wc0), 32'd0);

        // flush in START: pulse still issued, then idle
        @(negedge clock);
        in_valid = 1'b1; in_is_mult = 1'b1;
        @(negedge clock); in_valid = 1'b0; in_is_mult = 1'b0; flush = 1'b1;
        #1;
        check("flush_start_pulse", 32'(md_ctrl_MULT), 32'd1);
        check("flush_start_stall", 32'(stall), 32'd0);
        @(negedge clock); flush = 1'b0;
        #1 check("flush_start_busy", 32'(busy), 32'd0);

        // flush in IDLE suppresses launch
        @(negedge clock);
        in_valid = 1'b1; in_is_mult = 1'b1; flush = 1'b1;
        #1 check("flush_idle_stall", 32'(stall), 32'd0);
        @(negedge clock); in_valid = 1'b0; in_is_mult = 1'b0; flush = 1'b0;
        #1 check("flush_idle_busy", 32'(busy), 32'd0);

        // async reset mid-WAIT
        @(negedge clock);
        in_valid = 1'b1; in_is_mult = 1'b1; in_opA = 32'h55; in_rd = 5'd6;
        @(negedge clock); in_valid = 1'b0; in_is_mult = 1'b0;
        @(negedge clock); @(negedge clock);
        #1 check("pre_rst_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_opA", md_opA, 32'd0);
        check("arst_wb_valid", 32'(wb_valid), 32'd0);
        check("arst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        @(negedge clock); reset = 1'b0;
        @(negedge clock); #1 check("post_rst_busy", 32'(busy), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
